// File: rtl/mem_to_fifo_pkg.sv
// Shared dflow definitions for the memory replay path: FSM state encoding and
// default datapath widths.
package mem_to_fifo_pkg;

  localparam int unsigned DFLOW_MEM_ADDR_WIDTH  = 19;
  localparam int unsigned DFLOW_MEM_DATA_WIDTH  = 144;
  localparam int unsigned DFLOW_FIFO_DATA_WIDTH = 144;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_FLUSH
  } replay_state_e;

endpackage

// File: rtl/mem_to_fifo_rd_credit_ctr.sv
// Read credit tracker: counts in-flight reads, gates new issues at
// MAX_OUTSTANDING and flags read returns that arrive with nothing in flight.
module rd_credit_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_i,
  input  logic                              rd_valid_i,
  output logic                              can_issue_o,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              rd_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             spurious;

  // A return with nothing in flight is an error and must not underflow the count.
  assign spurious = rd_valid_i && (cnt_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | spurious;
    unique case ({issue_i, rd_valid_i && !spurious})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign can_issue_o   = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign outstanding_o = cnt_q;
  assign rd_err_o      = err_q;

endmodule

// File: rtl/mem_to_fifo.sv
// Replay engine: re-reads the record window from external memory in address
// order, one or more passes, and pushes each returned word into the TX FIFO.
module mem_to_fifo
  import mem_to_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = DFLOW_FIFO_DATA_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH  = DFLOW_MEM_ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH  = DFLOW_MEM_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned LOOP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       app_rd_cmd,
  output logic [MEM_ADDR_WIDTH-1:0]  app_rd_addr,
  input  logic                       app_rd_valid,
  input  logic [MEM_DATA_WIDTH-1:0]  app_rd_data,
  output logic                       fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       fifo_prog_full,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_high,
  input  logic [LOOP_WIDTH-1:0]      loop_count,
  input  logic                       start_replay,
  input  logic                       cal_done,
  input  logic                       sw_rst,
  output logic                       replay_busy,
  output logic                       replay_done,
  output logic [LOOP_WIDTH-1:0]      pass_cnt,
  output logic                       rd_err
);

  replay_state_e state_q, state_d;

  logic [MEM_ADDR_WIDTH-1:0]  low_q, low_d, high_q, high_d;
  logic [MEM_ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d, rd_addr_q, rd_addr_d;
  logic [LOOP_WIDTH-1:0]      loop_q, loop_d, pass_q, pass_d;
  logic                       start_prev_q, rd_cmd_q, wr_en_q, busy_q, done_q;
  logic [FIFO_DATA_WIDTH-1:0] wr_data_q;

  logic                              start_rise, issue, can_issue, last_word;
  logic [$clog2(MAX_OUTSTANDING):0]  outstanding;

  assign start_rise = start_replay && !start_prev_q;
  assign issue      = (state_q == ST_RUN) && !sw_rst && cal_done &&
                      !fifo_prog_full && can_issue;
  assign last_word  = (rd_ptr_q == (high_q - 1'b1));

  rd_credit_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .issue_i       (issue),
    .rd_valid_i    (app_rd_valid),
    .can_issue_o   (can_issue),
    .outstanding_o (outstanding),
    .rd_err_o      (rd_err)
  );

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    high_d    = high_q;
    loop_d    = loop_q;
    rd_ptr_d  = rd_ptr_q;
    pass_d    = pass_q;
    rd_addr_d = issue ? rd_ptr_q : rd_addr_q;

    if (sw_rst && state_q != ST_FLUSH) begin
      state_d  = (outstanding != '0) ? ST_FLUSH : ST_IDLE;
      rd_ptr_d = '0;
      pass_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            low_d    = dflow_addr_low;
            high_d   = dflow_addr_high;
            loop_d   = loop_count;
            rd_ptr_d = dflow_addr_low;
            pass_d   = '0;
            state_d  = (dflow_addr_high <= dflow_addr_low) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_word) begin
              pass_d = pass_q + 1'b1;
              // loop_count of zero means loop until aborted.
              if (loop_q != '0 && pass_d == loop_q) state_d = ST_DRAIN;
              else                                  rd_ptr_d = low_q;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
        ST_DRAIN: if (outstanding == '0) state_d = ST_DONE;
        ST_DONE:  if (!start_replay)     state_d = ST_IDLE;
        ST_FLUSH: if (outstanding == '0) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      low_q        <= '0;
      high_q       <= '0;
      loop_q       <= '0;
      rd_ptr_q     <= '0;
      pass_q       <= '0;
      rd_addr_q    <= '0;
      start_prev_q <= 1'b0;
      rd_cmd_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_q        <= low_d;
      high_q       <= high_d;
      loop_q       <= loop_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_q       <= pass_d;
      rd_addr_q    <= rd_addr_d;
      start_prev_q <= start_replay;
      rd_cmd_q     <= issue;
      // Returns are forwarded only while replaying; FLUSH and idle drop them.
      wr_en_q      <= app_rd_valid && (state_q == ST_RUN || state_q == ST_DRAIN);
      if (app_rd_valid) wr_data_q <= FIFO_DATA_WIDTH'(app_rd_data);
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                      (state_d == ST_FLUSH);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign app_rd_cmd  = rd_cmd_q;
  assign app_rd_addr = rd_addr_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_data   = wr_data_q;
  assign replay_busy = busy_q;
  assign replay_done = done_q;
  assign pass_cnt    = pass_q;

endmodule

// File: tb/tb_mem_to_fifo.sv
// Directed bench for mem_to_fifo with an in-order, variable-latency memory model.
`timescale 1ns/1ps
module tb_mem_to_fifo;

  localparam int AW = 19;
  localparam int DW = 144;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, app_rd_cmd, app_rd_valid, fifo_wr_en, fifo_prog_full;
  logic [AW-1:0] app_rd_addr, dflow_addr_low, dflow_addr_high;
  logic [DW-1:0] app_rd_data, fifo_data;
  logic [LW-1:0] loop_count, pass_cnt;
  logic          start_replay, cal_done, sw_rst, replay_busy, replay_done, rd_err;

  always #5 clk = ~clk;

  mem_to_fifo #(
    .FIFO_DATA_WIDTH (DW),
    .MEM_ADDR_WIDTH  (AW),
    .MEM_DATA_WIDTH  (DW),
    .MAX_OUTSTANDING (8),
    .LOOP_WIDTH      (LW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .app_rd_cmd      (app_rd_cmd),
    .app_rd_addr     (app_rd_addr),
    .app_rd_valid    (app_rd_valid),
    .app_rd_data     (app_rd_data),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data       (fifo_data),
    .fifo_prog_full  (fifo_prog_full),
    .dflow_addr_low  (dflow_addr_low),
    .dflow_addr_high (dflow_addr_high),
    .loop_count      (loop_count),
    .start_replay    (start_replay),
    .cal_done        (cal_done),
    .sw_rst          (sw_rst),
    .replay_busy     (replay_busy),
    .replay_done     (replay_done),
    .pass_cnt        (pass_cnt),
    .rd_err          (rd_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_req_t;

  rd_req_t       mem_q[$];
  logic [DW-1:0] wr_q[$];
  int  cyc, last_due, lat_min, lat_max, n_cmd, n_wr, outst, max_outst, lat_err;
  bit  mem_hold, spur_pulse, prev_valid;
  int  checks, failures;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {11'h5A5, {7{a}}};
  endfunction

  // Memory model and FIFO capture, evaluated on the falling edge.
  always @(negedge clk) begin
    int due;
    cyc++;
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_data);
      n_wr++;
      if (!prev_valid) lat_err++;
    end
    if (app_rd_cmd) begin
      n_cmd++;
      outst++;
      if (outst > max_outst) max_outst = outst;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: app_rd_addr, due: due});
    end
    app_rd_valid = 1'b0;
    app_rd_data  = '0;
    if (spur_pulse) begin
      app_rd_valid = 1'b1;
      app_rd_data  = mem_word('1);
      spur_pulse   = 1'b0;
    end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      app_rd_valid = 1'b1;
      app_rd_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
      outst--;
    end
    prev_valid = app_rd_valid;
  end

  task automatic do_reset();
    rst = 1'b1; start_replay = 1'b0; sw_rst = 1'b0; fifo_prog_full = 1'b0;
    cal_done = 1'b1; mem_hold = 1'b0;
    repeat (3) @(negedge clk);
    mem_q.delete(); wr_q.delete(); outst = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input logic [LW-1:0] loops);
    @(negedge clk);
    dflow_addr_low = lo; dflow_addr_high = hi; loop_count = loops;
    start_replay = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (replay_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (app_rd_cmd !== 1'b0) begin failures++; $display("FAIL rst_cmd: got %0b want 0", app_rd_cmd); end
    checks++; if (app_rd_addr !== '0) begin failures++; $display("FAIL rst_addr: got %0h want 0", app_rd_addr); end
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %0b want 0", fifo_wr_en); end
    checks++; if (fifo_data !== '0) begin failures++; $display("FAIL rst_data: got %0h want 0", fifo_data); end
    checks++; if (replay_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", replay_busy); end
    checks++; if (replay_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b want 0", replay_done); end
    checks++; if (pass_cnt !== '0) begin failures++; $display("FAIL rst_pass_cnt: got %0d want 0", pass_cnt); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL rst_rd_err: got %0b want 0", rd_err); end
  endtask

  task automatic test_single_pass();
    int first, c0;
    bit ok;
    lat_min = 5; lat_max = 5; lat_err = 0; wr_q.delete(); c0 = n_cmd;
    start_run(19'h10, 19'h14, 16'd1);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (app_rd_cmd) begin first = i; break; end
    end
    checks++; if (first !== 1) begin failures++; $display("FAIL start_to_cmd: got %0d want 1", first); end
    checks++; if (app_rd_addr !== 19'h10) begin failures++; $display("FAIL first_addr: got %0h want 10", app_rd_addr); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (app_rd_cmd !== 1'b1 || app_rd_addr !== AW'(32'h10 + i)) begin
        failures++; $display("FAIL burst_addr[%0d]: got cmd=%0b addr=%0h want cmd=1 addr=%0h", i, app_rd_cmd, app_rd_addr, 32'h10 + i);
      end
    end
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done: got timeout want replay_done"); end
    checks++; if (n_cmd - c0 !== 4) begin failures++; $display("FAIL single_cmds: got %0d want 4", n_cmd - c0); end
    checks++; if (wr_q.size() !== 4) begin failures++; $display("FAIL single_wr_count: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== mem_word(AW'(32'h10 + i))) begin failures++; $display("FAIL single_data[%0d]: got %0h want %0h", i, wr_q[i], mem_word(AW'(32'h10 + i))); end
    end
    checks++; if (pass_cnt !== 16'd1) begin failures++; $display("FAIL single_pass_cnt: got %0d want 1", pass_cnt); end
    checks++; if (replay_busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %0b want 0", replay_busy); end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL wr_latency: got %0d late writes want 0", lat_err); end
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (replay_done !== 1'b0) begin failures++; $display("FAIL done_to_idle: got %0b want 0", replay_done); end
  endtask

  task automatic test_multi_pass();
    int c0;
    bit ok;
    lat_min = 1; lat_max = 20; max_outst = 0; wr_q.delete(); c0 = n_cmd;
    start_run(19'h10, 19'h14, 16'd3);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL multi_done: got timeout want replay_done"); end
    checks++; if (wr_q.size() !== 12) begin failures++; $display("FAIL multi_wr_count: got %0d want 12", wr_q.size()); end
    for (int i = 0; i < 12 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== mem_word(AW'(32'h10 + i % 4))) begin failures++; $display("FAIL multi_data[%0d]: got %0h want %0h", i, wr_q[i], mem_word(AW'(32'h10 + i % 4))); end
    end
    checks++; if (n_cmd - c0 !== 12) begin failures++; $display("FAIL multi_cmds: got %0d want 12", n_cmd - c0); end
    checks++; if (pass_cnt !== 16'd3) begin failures++; $display("FAIL multi_pass_cnt: got %0d want 3", pass_cnt); end
    checks++; if (max_outst > 8) begin failures++; $display("FAIL max_outstanding: got %0d want <=8", max_outst); end
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_prog_full();
    int seen, held;
    bit ok;
    lat_min = 3; lat_max = 3; wr_q.delete();
    start_run(19'h10, 19'h18, 16'd2);
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(negedge clk);
      if (app_rd_cmd) seen++;
    end
    fifo_prog_full = 1'b1;
    held = 0;
    repeat (50) begin
      @(negedge clk);
      if (app_rd_cmd) held++;
    end
    fifo_prog_full = 1'b0;
    checks++; if (held !== 0) begin failures++; $display("FAIL cmd_during_full: got %0d want 0", held); end
    wait_done(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_done: got timeout want replay_done"); end
    checks++; if (wr_q.size() !== 16) begin failures++; $display("FAIL full_wr_count: got %0d want 16", wr_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== mem_word(AW'(32'h10 + i % 8))) begin failures++; $display("FAIL full_data[%0d]: got %0h want %0h", i, wr_q[i], mem_word(AW'(32'h10 + i % 8))); end
    end
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_window();
    int c0, w0;
    bit seen;
    c0 = n_cmd; w0 = n_wr; seen = 1'b0;
    start_run(19'h20, 19'h20, 16'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (replay_done) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL empty_done: got %0b want 1 within 2 cycles", seen); end
    repeat (5) @(negedge clk);
    checks++; if (n_cmd - c0 !== 0) begin failures++; $display("FAIL empty_cmds: got %0d want 0", n_cmd - c0); end
    checks++; if (n_wr - w0 !== 0) begin failures++; $display("FAIL empty_writes: got %0d want 0", n_wr - w0); end
    checks++; if (replay_busy !== 1'b0) begin failures++; $display("FAIL empty_busy: got %0b want 0", replay_busy); end
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_restart();
    int c0, w0, seen;
    bit ok;
    lat_min = 2; lat_max = 2; mem_hold = 1'b1; c0 = n_cmd;
    start_run(19'h10, 19'h18, 16'd0);
    seen = 0;
    for (int i = 0; i < 50 && seen < 5; i++) begin
      @(negedge clk);
      if (app_rd_cmd) seen++;
    end
    fifo_prog_full = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (n_cmd - c0 !== 5) begin failures++; $display("FAIL abort_inflight: got %0d want 5", n_cmd - c0); end
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    checks++; if (replay_busy !== 1'b1) begin failures++; $display("FAIL flush_busy: got %0b want 1", replay_busy); end
    w0 = n_wr;
    mem_hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!replay_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL flush_idle: got timeout want busy low"); end
    checks++; if (n_wr - w0 !== 0) begin failures++; $display("FAIL flush_writes: got %0d want 0", n_wr - w0); end
    checks++; if (mem_q.size() !== 0) begin failures++; $display("FAIL flush_pending: got %0d want 0", mem_q.size()); end
    checks++; if (n_cmd - c0 !== 5) begin failures++; $display("FAIL flush_cmds: got %0d want 5", n_cmd - c0); end
    checks++; if (pass_cnt !== '0) begin failures++; $display("FAIL flush_pass_cnt: got %0d want 0", pass_cnt); end
    checks++; if (replay_done !== 1'b0) begin failures++; $display("FAIL flush_done: got %0b want 0", replay_done); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL flush_rd_err: got %0b want 0", rd_err); end
    fifo_prog_full = 1'b0;
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    start_run(19'h10, 19'h14, 16'd1);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_done: got timeout want replay_done"); end
    checks++; if (wr_q.size() !== 4) begin failures++; $display("FAIL restart_wr_count: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== mem_word(AW'(32'h10 + i))) begin failures++; $display("FAIL restart_data[%0d]: got %0h want %0h", i, wr_q[i], mem_word(AW'(32'h10 + i))); end
    end
    checks++; if (pass_cnt !== 16'd1) begin failures++; $display("FAIL restart_pass_cnt: got %0d want 1", pass_cnt); end
    start_replay = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_return();
    int w0;
    w0 = n_wr;
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL pre_spur_rd_err: got %0b want 0", rd_err); end
    spur_pulse = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL spur_rd_err: got %0b want 1", rd_err); end
    checks++; if (n_wr - w0 !== 0) begin failures++; $display("FAIL spur_writes: got %0d want 0", n_wr - w0); end
    repeat (20) @(negedge clk);
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL spur_sticky: got %0b want 1", rd_err); end
    do_reset();
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL spur_cleared: got %0b want 0", rd_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; last_due = 0; n_cmd = 0; n_wr = 0;
    outst = 0; max_outst = 0; lat_err = 0; lat_min = 1; lat_max = 1;
    mem_hold = 1'b0; spur_pulse = 1'b0; prev_valid = 1'b0;
    app_rd_valid = 1'b0; app_rd_data = '0;
    dflow_addr_low = '0; dflow_addr_high = '0; loop_count = '0;
    rst = 1'b1; start_replay = 1'b0; sw_rst = 1'b0; fifo_prog_full = 1'b0; cal_done = 1'b1;
    do_reset();
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_prog_full();
    test_empty_window();
    test_abort_restart();
    test_spurious_return();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
